// File: rtl/frame_timing_gen.sv
// Frame/line timing generator.
// Produces the outV/outH strobes for the image-source stage. A frame is
// vertical front porch, active lines, vertical back porch, then inter-frame
// blanking. Every output is a register fed from the next-state logic, so the
// strobes change exactly one cycle after the state decision is made.
module frame_timing_gen #(
  parameter int H_ACTIVE   = 2448,
  parameter int H_BLANK    = 64,
  parameter int V_ACTIVE   = 2048,
  parameter int V_FRONT    = 4,
  parameter int V_BACK     = 4,
  parameter int F_BLANK    = 16,
  parameter int NUM_FRAMES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        outV,
  output logic        outH,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] line_cnt,
  output logic [15:0] frame_cnt
);

  // Horizontal geometry.
  localparam int LINE = H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LINE);

  // The vertical counter must hold the longest line sequence of any state,
  // and is never narrower than the 16-bit line_cnt view.
  localparam int MAX_FA = (V_FRONT > V_ACTIVE) ? V_FRONT : V_ACTIVE;
  localparam int MAX_BF = (V_BACK > F_BLANK) ? V_BACK : F_BLANK;
  localparam int MAXV   = (MAX_FA > MAX_BF) ? MAX_FA : MAX_BF;
  localparam int VBITS  = $clog2(MAXV + 32'sd1);
  localparam int VW     = (VBITS > 16) ? VBITS : 16;

  localparam logic [HW-1:0] H_ZERO = HW'(1'b0);
  localparam logic [HW-1:0] H_ONE  = HW'(1'b1);
  localparam logic [HW-1:0] H_LAST = HW'(LINE - 32'sd1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);

  localparam logic [VW-1:0] V_ZERO  = VW'(1'b0);
  localparam logic [VW-1:0] V_ONE   = VW'(1'b1);
  // A zero-length porch wraps to all ones here; that state is then never
  // entered, so the value is never compared.
  localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 32'sd1);
  localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 32'sd1);
  localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 32'sd1);
  localparam logic [VW-1:0] FB_LAST = VW'(F_BLANK - 32'sd1);

  localparam logic [15:0] NF_TARGET = 16'(NUM_FRAMES);
  localparam logic [15:0] FRAME_MAX = 16'hFFFF;
  localparam logic        LIMITED   = (NUM_FRAMES != 32'sd0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VFRONT = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_VBACK  = 3'd3,
    ST_FBLANK = 3'd4
  } state_t;

  // Entry point of every frame and the successor of the active region,
  // with zero-length porches skipped.
  localparam state_t FIRST_STATE  = (V_FRONT == 32'sd0) ? ST_ACTIVE : ST_VFRONT;
  localparam state_t AFTER_ACTIVE = (V_BACK == 32'sd0) ? ST_FBLANK : ST_VBACK;

  state_t        state_r;
  state_t        stateNext_s;
  logic [HW-1:0] hcnt_r;
  logic [HW-1:0] hcntNext_s;
  logic [VW-1:0] vcnt_r;
  logic [VW-1:0] vcntNext_s;
  logic          stopPend_r;
  logic          stopPendNext_s;
  logic [15:0]   frameCnt_r;
  logic [15:0]   frameCntNext_s;
  logic          lineEnd_s;
  logic          runDone_s;
  logic          enterFblank_s;
  logic          outVNext_s;
  logic          outHNext_s;
  logic          outV_r;
  logic          outH_r;
  logic          frameDone_r;
  logic          busy_r;

  assign lineEnd_s     = (hcnt_r == H_LAST);
  assign runDone_s     = LIMITED && (frameCnt_r == NF_TARGET);
  assign enterFblank_s = (stateNext_s == ST_FBLANK) && (state_r != ST_FBLANK);
  assign outVNext_s    = (stateNext_s == ST_VFRONT) || (stateNext_s == ST_ACTIVE) ||
                         (stateNext_s == ST_VBACK);
  assign outHNext_s    = (stateNext_s == ST_ACTIVE) && (hcntNext_s < H_ACT);

  // State sequencing: each region lasts a whole number of lines, so every
  // transition happens on the last cycle of a line.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          stateNext_s = FIRST_STATE;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_VFRONT: begin
        if (lineEnd_s && (vcnt_r == VF_LAST)) begin
          stateNext_s = ST_ACTIVE;
        end else begin
          stateNext_s = ST_VFRONT;
        end
      end
      ST_ACTIVE: begin
        if (lineEnd_s && (vcnt_r == VA_LAST)) begin
          stateNext_s = AFTER_ACTIVE;
        end else begin
          stateNext_s = ST_ACTIVE;
        end
      end
      ST_VBACK: begin
        if (lineEnd_s && (vcnt_r == VB_LAST)) begin
          stateNext_s = ST_FBLANK;
        end else begin
          stateNext_s = ST_VBACK;
        end
      end
      ST_FBLANK: begin
        if (lineEnd_s && (vcnt_r == FB_LAST)) begin
          if (stopPend_r || runDone_s) begin
            stateNext_s = ST_IDLE;
          end else begin
            stateNext_s = FIRST_STATE;
          end
        end else begin
          stateNext_s = ST_FBLANK;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // Counter and bookkeeping next values: pixel/line counters, pending stop
  // and completed-frame count.
  always_comb begin
    hcntNext_s     = H_ZERO;
    vcntNext_s     = V_ZERO;
    stopPendNext_s = 1'b0;
    frameCntNext_s = frameCnt_r;
    if (state_r == ST_IDLE) begin
      // Counters rest at zero; a start captures a simultaneous stop so that
      // exactly one frame runs.
      if (stateNext_s != ST_IDLE) begin
        stopPendNext_s = stop;
        frameCntNext_s = 16'h0000;
      end else begin
        stopPendNext_s = 1'b0;
        frameCntNext_s = frameCnt_r;
      end
    end else begin
      if (lineEnd_s) begin
        hcntNext_s = H_ZERO;
      end else begin
        hcntNext_s = hcnt_r + H_ONE;
      end

      if (stateNext_s != state_r) begin
        vcntNext_s = V_ZERO;
      end else if (lineEnd_s) begin
        vcntNext_s = vcnt_r + V_ONE;
      end else begin
        vcntNext_s = vcnt_r;
      end

      // A stop only takes effect at the end of the current frame.
      if (stateNext_s == ST_IDLE) begin
        stopPendNext_s = 1'b0;
      end else begin
        stopPendNext_s = stopPend_r | stop;
      end

      if (enterFblank_s && (frameCnt_r != FRAME_MAX)) begin
        frameCntNext_s = frameCnt_r + 16'h0001;
      end else begin
        frameCntNext_s = frameCnt_r;
      end
    end
  end

  // State, counter and output registers; reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      hcnt_r      <= H_ZERO;
      vcnt_r      <= V_ZERO;
      stopPend_r  <= 1'b0;
      frameCnt_r  <= 16'h0000;
      outV_r      <= 1'b0;
      outH_r      <= 1'b0;
      frameDone_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      hcnt_r      <= hcntNext_s;
      vcnt_r      <= vcntNext_s;
      stopPend_r  <= stopPendNext_s;
      frameCnt_r  <= frameCntNext_s;
      outV_r      <= outVNext_s;
      outH_r      <= outHNext_s;
      frameDone_r <= enterFblank_s;
      busy_r      <= (stateNext_s != ST_IDLE);
    end
  end

  assign outV       = outV_r;
  assign outH       = outH_r;
  assign frame_done = frameDone_r;
  assign busy       = busy_r;
  assign line_cnt   = vcnt_r[15:0];
  assign frame_cnt  = frameCnt_r;

endmodule

// File: doc/frame_timing_gen.md
# frame_timing_gen

Frame/line timing generator that produces the `inV`/`inH` strobes consumed by the image-source stage of the simulation bench. Each frame is a programmable sequence of vertical front porch, active lines, vertical back porch and inter-frame blanking. Line and frame counters are exposed for monitors. It sits directly upstream of the image-source stage, which must see exactly `H_ACTIVE*V_ACTIVE` cycles of `V&H` per frame.

## Interface
- `H_ACTIVE`, 2448: active pixels per line (>=1)
- `H_BLANK`, 64: horizontal blanking cycles per line (>=1)
- `V_ACTIVE`, 2048: active lines per frame (>=1)
- `V_FRONT`, 4: lines with V=1, H=0 before the first active line (>=0)
- `V_BACK`, 4: lines with V=1, H=0 after the last active line (>=0)
- `F_BLANK`, 16: lines with V=0 between frames (>=1)
- `NUM_FRAMES`, 0: frames per run; 0 = free-running until `stop`
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: start request, sampled only in IDLE
- `stop` in 1: finish the current frame, then go IDLE
- `outV` out 1: frame valid
- `outH` out 1: line valid (active pixels only)
- `frame_done` out 1: one-cycle pulse at the end of each frame's V period
- `busy` out 1: high whenever the state is not IDLE
- `line_cnt` out 16: line index within the current state's line sequence
- `frame_cnt` out 16: completed frames since the last `start`

## Operation
- LINE = `H_ACTIVE+H_BLANK` cycles. `hcnt` counts 0..LINE-1 and wraps in every non-IDLE state. `vcnt` counts lines within the current state and clears on each state change.
- States and transitions:
  - IDLE -> VFRONT on `start`, or -> ACTIVE on `start` if `V_FRONT`=0.
  - VFRONT -> ACTIVE after `V_FRONT` lines.
  - ACTIVE -> VBACK after `V_ACTIVE` lines, or -> FBLANK if `V_BACK`=0.
  - VBACK -> FBLANK after `V_BACK` lines.
  - FBLANK -> IDLE after `F_BLANK` lines if `stop_pend`, or if `NUM_FRAMES`!=0 and `frame_cnt`==`NUM_FRAMES`. Otherwise FBLANK -> VFRONT (or ACTIVE).
- `outV`=1 in VFRONT, ACTIVE and VBACK. `outH`=1 only in ACTIVE with `hcnt`<`H_ACTIVE`. Both are registered outputs of the next-state logic.
- `frame_done`=1 for the single cycle in which the state first enters FBLANK. `frame_cnt` increments (saturating at 0xFFFF) in that same cycle.
- `stop` is latched into `stop_pend` in any non-IDLE cycle. `stop_pend` clears on entry to IDLE. A frame is never truncated.
- `start` while busy is ignored.
- `start`&`stop` together in IDLE: exactly one frame runs (`stop_pend` set).
- On leaving IDLE, `frame_cnt` clears to 0.
- `line_cnt` = `vcnt[15:0]`.

## Timing
- Reset: the state goes to IDLE. `outV`, `outH`, `frame_done`, `busy` = 0. `line_cnt`, `frame_cnt`, `hcnt`, `vcnt`, `stop_pend` = 0.
- `rst` mid-frame: all outputs drop to 0 on the next edge. There is no pending state, and the same reset values apply.
- `start` sampled at edge t: `busy`=1 and `outV`=1 from cycle t+1. The first `outH` rises at t+1+`V_FRONT`*LINE.
- Within each active line, `outH` is high for exactly `H_ACTIVE` consecutive cycles, then low for `H_BLANK` cycles.
- `outV` high period = (`V_FRONT`+`V_ACTIVE`+`V_BACK`)*LINE cycles. Frame period = that value + `F_BLANK`*LINE.
- `outH` never rises while `outV`=0. `outV` never changes while `outH`=1.
- After the final frame, `busy` falls on the cycle after the last FBLANK cycle.

## Test plan
Common parameters: `H_ACTIVE`=4, `H_BLANK`=2, `V_ACTIVE`=3, `V_FRONT`=1, `V_BACK`=1, `F_BLANK`=2, `NUM_FRAMES`=2. Start pulses at cycle 0.
- Basic frame -> `outV` is high in cycles 1..30. `outH` is high in cycles 7..10, 13..16 and 19..22. `frame_done` pulses at cycle 31. There are 12 `V&H` cycles per frame.
- NUM_FRAMES=2 -> the second `outV` rises at cycle 43 and `frame_done` pulses at cycle 73. `frame_cnt` reads 2 and `busy` falls at cycle 85.
- Free-running (`NUM_FRAMES`=0) with `stop` pulsed at cycle 50 -> frame 2 completes unchanged (`frame_done` at 73) and `busy`=0 from cycle 85. A `start` at cycle 20 has no effect.
- Same `start`&`stop` cycle in IDLE -> exactly one frame runs: `frame_done` at 31, `busy`=0 from cycle 43.
- `rst` at cycle 15 (mid active line) -> all outputs are 0 from cycle 16. A `start` at cycle 20 reproduces the basic frame offset by 20 cycles.
- `V_FRONT`=0, `V_BACK`=0 -> `outV` and `outH` both rise at cycle 1. `outV` is high in cycles 1..18 and `frame_done` pulses at cycle 19.
